// File: rtl/seg_display_arbiter.sv
// rtl/seg_display_arbiter.sv - frame-arbitrated 4-digit 7-segment display driver
//
// Shares one multiplexed 4-digit display between four prioritised service
// blocks and the idle (time-of-day) word. At every scan-frame boundary the
// lowest-index active request wins and its BCD word is snapshotted. That word
// is then scanned digit by digit, with cursor blink and alarm flash applied.
//
// Parameters:
//   SCAN_DIV   clk_osc cycles per digit slot
//   BLINK_DIV  clk_osc cycles per blink half-period
//
// Ports:
//   clk_osc     in   1   system oscillator clock
//   reset       in   1   asynchronous, active-high reset
//   req         in   4   display requests, bit 0 = highest priority
//   data0..3    in  16   BCD word of each requester, [3:0] = rightmost digit
//   idle_data   in  16   BCD word shown when nothing is granted
//   cursor      in   4   one-hot digit blink mask, sampled live
//   flash       in   1   alarm flash request, sampled live
//   anode       out  4   active-low digit enables, 4'b1110 = rightmost digit
//   seg         out  7   active-low segments, bit order gfedcba
//   grant       out  4   one-hot current owner, 0000 = idle source
//   frame_tick  out  1   high for the cycle in which a new grant/snapshot is live
//
// Build option:
//   SEG_ARB_ZERO_BLANK_EN  blank a leading zero in digit 3 (not while flashing)

module seg_display_arbiter #(
  parameter int SCAN_DIV  = 2048,
  parameter int BLINK_DIV = 8388608
) (
  input  logic        clk_osc,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  input  logic [15:0] data3,
  input  logic [15:0] idle_data,
  input  logic [3:0]  cursor,
  input  logic        flash,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic [3:0]  grant,
  output logic        frame_tick
);

  localparam int CW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ALL   = 7'b0000000;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Scan and blink timebase
  logic [CW-1:0] cnt;
  logic [1:0]    digit;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  // Frozen frame contents
  logic [15:0]   snap;

  logic          slot_end;
  logic          frame_end;
  logic          blink_end;

  logic [3:0]    next_grant;
  logic [15:0]   next_snap;

  logic [3:0]    nibble;
  logic [6:0]    digit_seg;
  logic [3:0]    scan_anode;
  logic [3:0]    next_anode;
  logic [6:0]    next_seg;

  assign slot_end  = (cnt == SCAN_LAST);
  assign frame_end = slot_end && (digit == 2'd3);
  assign blink_end = (blink_cnt == BLINK_LAST);

  // Fixed-priority choice of the next owner, evaluated every cycle but only
  // captured on the frame boundary.
  always_comb begin
    next_grant = 4'b0000;
    next_snap  = idle_data;
    if (req[0]) begin
      next_grant = 4'b0001;
      next_snap  = data0;
    end else if (req[1]) begin
      next_grant = 4'b0010;
      next_snap  = data1;
    end else if (req[2]) begin
      next_grant = 4'b0100;
      next_snap  = data2;
    end else if (req[3]) begin
      next_grant = 4'b1000;
      next_snap  = data3;
    end
  end

  // Digit slot counter and digit index
  always_ff @(posedge clk_osc or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      digit <= 2'd0;
    end else if (slot_end) begin
      cnt   <= '0;
      digit <= digit + 2'd1;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

  // Blink half-period timer, free-running and independent of the scan
  always_ff @(posedge clk_osc or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_end) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end

  // Grant and snapshot only move on the frame boundary so a frame is never
  // torn between two sources; pre-emption waits for the boundary too.
  always_ff @(posedge clk_osc or posedge reset) begin
    if (reset) begin
      grant      <= 4'b0000;
      snap       <= 16'h0000;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_end;
      if (frame_end) begin
        grant <= next_grant;
        snap  <= next_snap;
      end
    end
  end

  // Select the nibble for the digit currently being scanned
  always_comb begin
    case (digit)
      2'd0:    nibble = snap[3:0];
      2'd1:    nibble = snap[7:4];
      2'd2:    nibble = snap[11:8];
      default: nibble = snap[15:12];
    endcase
  end

  // BCD to active-low gfedcba; non-decimal codes blank the digit
  function automatic logic [6:0] seg_decode(input logic [3:0] value);
    case (value)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

  assign digit_seg  = seg_decode(nibble);
  assign scan_anode = ~(4'b0001 << digit);

  // Flash takes precedence over both cursor blink and the data pattern.
  // During the dark flash phase the segments are also blanked so nothing
  // leaks through if a board ties anodes differently.
  always_comb begin
    next_anode = scan_anode;
    next_seg   = digit_seg;
    if (flash) begin
      if (blink_phase) begin
        next_seg = SEG_ALL;
      end else begin
        next_anode = AN_OFF;
        next_seg   = SEG_BLANK;
      end
    end else begin
      if (blink_phase && cursor[digit]) begin
        next_anode = AN_OFF;
      end
`ifdef SEG_ARB_ZERO_BLANK_EN
      if ((digit == 2'd3) && (snap[15:12] == 4'd0)) begin
        next_seg = SEG_BLANK;
      end
`else
`endif
    end
  end

  // Registered pin drivers: one cycle behind the scan state
  always_ff @(posedge clk_osc or posedge reset) begin
    if (reset) begin
      anode <= AN_OFF;
      seg   <= SEG_BLANK;
    end else begin
      anode <= next_anode;
      seg   <= next_seg;
    end
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb/tb_seg_display_arbiter.sv - self-checking bench for seg_display_arbiter

module tb_seg_display_arbiter;

  localparam int SD    = 4;
  localparam int BD    = 32;
  localparam int FRAME = 4 * SD;

  logic        clk_osc = 1'b0;
  logic        reset   = 1'b1;
  logic [3:0]  req     = 4'b0000;
  logic [15:0] data0   = 16'h0000;
  logic [15:0] data1   = 16'h0000;
  logic [15:0] data2   = 16'h0000;
  logic [15:0] data3   = 16'h0000;
  logic [15:0] idle_data = 16'h1234;
  logic [3:0]  cursor  = 4'b0000;
  logic        flash   = 1'b0;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic [3:0]  grant;
  logic        frame_tick;

  int checks = 0;
  int passes = 0;

  seg_display_arbiter #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk_osc    (clk_osc),
    .reset      (reset),
    .req        (req),
    .data0      (data0),
    .data1      (data1),
    .data2      (data2),
    .data3      (data3),
    .idle_data  (idle_data),
    .cursor     (cursor),
    .flash      (flash),
    .anode      (anode),
    .seg        (seg),
    .grant      (grant),
    .frame_tick (frame_tick)
  );

  always #5 clk_osc = ~clk_osc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference glyphs for decimal digits, active-low gfedcba
  function automatic logic [6:0] glyph(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected segments of digit d of a word, with no flash active
  function automatic logic [6:0] word_seg(input logic [15:0] w, input int d);
    int v;
    v = int'((w >> (4 * d)) & 16'h000f);
`ifdef SEG_ARB_ZERO_BLANK_EN
    if (d == 3 && v == 0) return 7'b1111111;
`endif
    return glyph(v);
  endfunction

  function automatic logic [3:0] digit_anode(input int d);
    logic [3:0] one;
    one = 4'b0001 << d;
    return ~one;
  endfunction

  // ---------------- behavioural reference model ----------------
  // The display state is a pure function of the number of clock edges since
  // reset release: slot = k/SD, digit = slot mod 4, blink = (k/BD) mod 2,
  // and a new frame starts on every FRAME-th edge.
  int unsigned k;
  logic [3:0]  m_grant;
  logic [15:0] m_snap;
  logic [3:0]  e_anode;
  logic [6:0]  e_seg;
  logic        e_tick;

  function automatic logic [3:0] pick_grant(input logic [3:0] r);
    for (int i = 0; i < 4; i++) if (r[i]) return 4'(1 << i);
    return 4'b0000;
  endfunction

  function automatic logic [15:0] pick_word(input logic [3:0] r, input logic [15:0] w0,
      input logic [15:0] w1, input logic [15:0] w2, input logic [15:0] w3, input logic [15:0] wi);
    logic [15:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int i = 0; i < 4; i++) if (r[i]) return w[i];
    return wi;
  endfunction

  function automatic logic [3:0] model_anode(input int d, input int ph, input logic [3:0] cur, input logic fl);
    if (fl) return (ph == 1) ? digit_anode(d) : 4'b1111;
    if (ph == 1 && cur[d]) return 4'b1111;
    return digit_anode(d);
  endfunction

  function automatic logic [6:0] model_seg(input int d, input logic [15:0] w, input logic fl);
    if (fl) return 7'b0000000;
    return word_seg(w, d);
  endfunction

  always @(posedge clk_osc or posedge reset) begin
    if (reset) begin
      k       <= 0;
      m_grant <= 4'b0000;
      m_snap  <= 16'h0000;
      e_anode <= 4'b1111;
      e_seg   <= 7'b1111111;
      e_tick  <= 1'b0;
    end else begin
      k       <= k + 1;
      e_anode <= model_anode(int'((k / SD) % 4), int'((k / BD) % 2), cursor, flash);
      e_seg   <= model_seg(int'((k / SD) % 4), m_snap, flash);
      e_tick  <= (k % FRAME == FRAME - 1);
      if (k % FRAME == FRAME - 1) begin
        m_grant <= pick_grant(req);
        m_snap  <= pick_word(req, data0, data1, data2, data3, idle_data);
      end
    end
  end

  // Segments are only meaningful while a digit is lit
  task automatic mcheck();
    check("m_grant", grant, m_grant);
    check("m_frame_tick", frame_tick, e_tick);
    check("m_anode", anode, e_anode);
    if (e_anode != 4'b1111) check("m_seg", seg, e_seg);
  endtask

  task automatic model_run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_osc); @(negedge clk_osc);
      mcheck();
    end
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(posedge clk_osc); @(negedge clk_osc);
      n++;
    end while (!frame_tick && n < 3 * FRAME);
    check("frame_tick_wait", frame_tick, 1);
  endtask

  // Check digit slots first..last of one frame showing word w
  task automatic show_frame(input logic [15:0] w, input int first, input int last);
    for (int s = first; s <= last; s++) begin
      @(posedge clk_osc); @(negedge clk_osc);
      check("frame_anode", anode, digit_anode(s / SD));
      check("frame_seg", seg, word_seg(w, s / SD));
    end
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [15:0] d0, d1, d2, d3, idle;
    logic [3:0]  exp_grant;
    logic [15:0] exp_word;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 4'b0000, 16'h1234};
    vecs[1] = '{4'b1010, 16'h0000, 16'h0559, 16'h0000, 16'h9999, 16'h1234, 4'b0010, 16'h0559};
    vecs[2] = '{4'b1000, 16'h1111, 16'h2222, 16'h3333, 16'h9999, 16'h1234, 4'b1000, 16'h9999};
    vecs[3] = '{4'b0100, 16'h1111, 16'h2222, 16'hAB07, 16'h9999, 16'h1234, 4'b0100, 16'hAB07};
    vecs[4] = '{4'b1111, 16'h8086, 16'h2222, 16'h3333, 16'h4444, 16'h1234, 4'b0001, 16'h8086};

    // Reset state
    repeat (3) @(posedge clk_osc);
    @(negedge clk_osc);
    check("rst_anode", anode, 4'b1111);
    check("rst_seg", seg, 7'b1111111);
    check("rst_grant", grant, 4'b0000);
    check("rst_tick", frame_tick, 0);
    reset = 1'b0;

    // First output: digit 0 of the zero snapshot
    @(posedge clk_osc); @(negedge clk_osc);
    check("first_anode", anode, 4'b1110);
    check("first_seg", seg, 7'b1000000);

    // Table-driven frames
    foreach (vecs[i]) begin
      req = vecs[i].req;
      data0 = vecs[i].d0; data1 = vecs[i].d1; data2 = vecs[i].d2; data3 = vecs[i].d3;
      idle_data = vecs[i].idle;
      wait_tick();
      check("vec_grant", grant, vecs[i].exp_grant);
      show_frame(vecs[i].exp_word, 0, FRAME - 1);
    end

    // Mid-frame pre-emption waits for the boundary
    req = 4'b1010; data0 = 16'h0000; data1 = 16'h0559; data3 = 16'h9999;
    wait_tick();
    check("pre_grant", grant, 4'b0010);
    show_frame(16'h0559, 0, 5);
    req = 4'b1011; data0 = 16'h4321;
    show_frame(16'h0559, 6, FRAME - 1);
    check("pre_tick", frame_tick, 1);
    check("pre_new_grant", grant, 4'b0001);
    show_frame(16'h4321, 0, FRAME - 1);

    // Cursor blink on digit 2, then alarm flash
    req = 4'b0001;
    cursor = 4'b0100;
    model_run(3 * BD);
    cursor = 4'b0000;
    flash = 1'b1;
    model_run(3 * BD);
    check("flash_grant", grant, 4'b0001);
    flash = 1'b0;

    // Reset mid-frame
    wait_tick();
    repeat (5) begin @(posedge clk_osc); @(negedge clk_osc); end
    check("mid_grant", grant, 4'b0001);
    reset = 1'b1;
    #1;
    check("mid_rst_anode", anode, 4'b1111);
    check("mid_rst_seg", seg, 7'b1111111);
    check("mid_rst_grant", grant, 4'b0000);
    check("mid_rst_tick", frame_tick, 0);
    repeat (2) @(negedge clk_osc);
    reset = 1'b0;
    @(posedge clk_osc); @(negedge clk_osc);
    check("restart_anode", anode, 4'b1110);
    check("restart_seg", seg, 7'b1000000);

    // Randomised traffic against the reference model
    for (int i = 0; i < 800; i++) begin
      req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) data0 = 16'($urandom);
      if ($urandom_range(0, 3) == 0) data1 = 16'($urandom);
      if ($urandom_range(0, 3) == 0) data2 = 16'($urandom);
      if ($urandom_range(0, 3) == 0) data3 = 16'($urandom);
      if ($urandom_range(0, 7) == 0) idle_data = 16'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        int c;
        c = int'($urandom_range(0, 4));
        cursor = (c == 4) ? 4'b0000 : 4'(1 << c);
      end
      if ($urandom_range(0, 39) == 0) flash = ~flash;
      if (i == 400) begin
        reset = 1'b1;
        #1;
        mcheck();
        check("rnd_rst_seg", seg, 7'b1111111);
        @(negedge clk_osc);
        reset = 1'b0;
      end
      @(posedge clk_osc); @(negedge clk_osc);
      mcheck();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/seg_display_arbiter.md
# seg_display_arbiter

Shares the single 4-digit 7-segment display among the four service blocks and the free-running clock.
- At each scan-frame boundary it arbitrates the service requests by fixed priority.
- It snapshots the winner's BCD word and scans the digits.
- It applies cursor blinking and alarm flashing.
- It drives the board anode/segment pins directly, so the top level needs no scan or mux logic.

## Interface
Parameters:
- SCAN_DIV, 2048: clk_osc cycles per digit slot.
- BLINK_DIV, 8388608: clk_osc cycles per blink half-period.

Ports:
- clk_osc  in  1  system oscillator clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  4  display requests; bit 0 = service 1 (highest priority), bit 3 = service 4 (lowest).
- data0..data3  in  16 each  BCD word of requester n (4 nibbles, [3:0] = rightmost digit).
- idle_data  in  16  BCD word shown when no request is granted (current time).
- cursor  in  4  one-hot digit-blink mask for the granted source; bit i = digit i; sampled live.
- flash  in  1  alarm flash request; sampled live.
- anode  out  4  active-low digit enables; 4'b1110 = rightmost digit.
- seg  out  7  active-low segments, bit order gfedcba.
- grant  out  4  one-hot current owner; 0000 = idle source.
- frame_tick  out  1  one-cycle pulse on the edge where a new frame's grant/snapshot load.

## Operation
- Scan counter cnt counts 0..SCAN_DIV-1. At terminal count:
  - cnt returns to 0;
  - digit index advances 0→1→2→3→0.
- Frame boundary is the edge where cnt==SCAN_DIV-1 and digit==3. On that edge:
  - grant ← lowest-index set bit of req, or 0000 if req==0;
  - snap ← data of the new grant, or idle_data if none;
  - frame_tick=1 for that cycle.
- Between boundaries, grant and snap are frozen:
  - req changes, drops and new requests take effect only at the next boundary;
  - a higher-priority request pre-empts the current owner only at the boundary.
- Digit decode uses nibble snap[4·digit+3 : 4·digit]:
  - values 0–9 map to standard patterns (0 = 7'b1000000, 8 = 7'b0000000);
  - values 10–15 give seg=7'b1111111 (blank).
- Blink: blink_phase toggles every BLINK_DIV cycles. If blink_phase=1 and cursor[digit]=1, anode=4'b1111 for that slot.
- Flash overrides cursor and data:
  - flash=1, blink_phase=1: seg=7'b0000000 on every digit, normal anode scan;
  - flash=1, blink_phase=0: anode=4'b1111.
- Reset mid-frame aborts the frame immediately. Scanning restarts at digit 0 after reset deasserts.

## Timing
- Reset values:
  - anode=4'b1111, seg=7'b1111111, grant=4'b0000, frame_tick=0;
  - cnt=0, digit=0, blink_phase=0, snap=16'h0000.
- anode and seg are registered. They reflect the digit, snap, cursor and flash values of the previous cycle, i.e. one cycle of latency after a digit advance.
- First output after reset release: digit 0 of snap=0000, displayed 1 cycle after the first edge.
- Frame period is 4·SCAN_DIV cycles.
- Worst-case request-to-display latency is 4·SCAN_DIV+1 cycles:
  - up to 4·SCAN_DIV cycles waiting for the boundary;
  - plus 1 cycle of output register.
- grant changes only on frame_tick edges.

## Configuration
- Macro SEG_ARB_ZERO_BLANK_EN.
- Defined: if snap[15:12]==0, digit 3 is blanked (seg=7'b1111111). This does not apply while flash overrides the display.
- Undefined: a zero in digit 3 displays as "0".

## Test plan
Bench uses SCAN_DIV=4, BLINK_DIV=32.
- Reset, then req=0, idle_data=16'h1234. After the first boundary, anode cycles 1110/1101/1011/0111 with seg showing 4, 3, 2, 1. grant=0000.
- req=4'b1010, data1=16'h0559, data3=16'h9999 → at the next frame_tick grant=0010 and the display shows 0559.
  - With SEG_ARB_ZERO_BLANK_EN, digit 3 is blank.
- While grant=0010, raise req[0] with data0=16'h4321 mid-frame. The current frame still shows 0559; the next frame shows 4321 with grant=0001.
- Granted source with cursor=4'b0100: digit 2 anode is 1111 during blink_phase=1 slots and shows normally during blink_phase=0.
- flash=1: all digits show seg=0000000 for 32 cycles, then anode=1111 for 32 cycles, alternating; grant is unchanged.
- Assert reset mid-frame with grant=0001: on the same edge outputs are anode=1111, seg=1111111, grant=0000. After release, scanning restarts at digit 0.
